// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: state encoding, key bit positions, coin values.
package vend_pkg;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StCollect  = 2'd1;
  localparam logic [1:0] StDispense = 2'd2;
  localparam logic [1:0] StRefund   = 2'd3;

  localparam int unsigned KEY_C05 = 0;
  localparam int unsigned KEY_C10 = 1;
  localparam int unsigned KEY_CAN = 2;
  localparam int unsigned KEY_BUY = 3;

  localparam logic [7:0] COIN_C05 = 8'd5;
  localparam logic [7:0] COIN_C10 = 8'd10;

  // Coin value of a key word already known to carry a coin; the 1-yuan key wins.
  function automatic logic [7:0] coin_value(input logic [3:0] key);
    return key[KEY_C10] ? COIN_C10 : COIN_C05;
  endfunction

endpackage

// File: rtl/vend_seq_ctrl_if.sv
// Key inputs and user-facing outputs of the vending sequencer.
interface vend_seq_ctrl_if;
  logic [3:0]  flag_key;
  logic [23:0] rNum;
  logic        dispense;
  logic        coin_ret;
  logic        deny;
  logic        busy;

  modport master (output flag_key, input rNum, dispense, coin_ret, deny, busy);
  modport slave  (input flag_key, output rNum, dispense, coin_ret, deny, busy);
endinterface

// File: rtl/vend_bin2bcd.sv
// Combinational 8-bit binary to three-digit BCD (shift-and-add-3).
module vend_bin2bcd (
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o
);

  logic [19:0] sh;

  always_comb begin
    sh = {12'd0, bin_i};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8] >= 4'd5)  sh[11:8]  = sh[11:8] + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    bcd_o = sh[19:8];
  end

endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending sequencer: coin credit, purchase/dispense timing, paced change return, BCD display.
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE      = 25,
  parameter int unsigned CREDIT_MAX = 200,
  parameter int unsigned DISP_CYC   = 50000000,
  parameter int unsigned RET_GAP    = 25000000
) (
  input logic            sclk,
  input logic            rst,
  vend_seq_ctrl_if.slave bus
);

  localparam logic [7:0]  Price     = 8'(PRICE);
  localparam logic [8:0]  CreditMax = 9'(CREDIT_MAX);
  localparam logic [31:0] DispLast  = 32'(DISP_CYC - 1);
  localparam logic [31:0] RetLast   = 32'(RET_GAP - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  credit_q, credit_d;
  logic [6:0]  sold_q, sold_d;
  logic [31:0] timer_q, timer_d;
  logic        deny_q, deny_d;
  logic [23:0] rnum_q, rnum_d;

  logic [8:0]  coin_sum;
  logic [11:0] credit_bcd, sold_bcd;
  logic        key_can, key_buy, key_coin, ret_pulse;

  assign key_can   = bus.flag_key[KEY_CAN];
  assign key_buy   = bus.flag_key[KEY_BUY];
  assign key_coin  = bus.flag_key[KEY_C10] | bus.flag_key[KEY_C05];
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value(bus.flag_key)};
  // Timer restarts at zero on REFUND entry, so the first cycle pulses immediately.
  assign ret_pulse = (state_q == StRefund) && (timer_q == 32'd0);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    sold_d   = sold_q;
    timer_d  = timer_q;
    deny_d   = 1'b0;
    case (state_q)
      StIdle, StCollect: begin
        if (key_can) begin
          if (state_q == StCollect) begin
            state_d = StRefund;
            timer_d = '0;
          end
        end else if (key_buy) begin
          if (credit_q >= Price) begin
            credit_d = credit_q - Price;
            sold_d   = (sold_q == 7'd99) ? 7'd0 : sold_q + 7'd1;
            state_d  = StDispense;
            timer_d  = '0;
          end else begin
            deny_d = 1'b1;
          end
        end else if (key_coin) begin
          if (coin_sum > CreditMax) begin
            deny_d = 1'b1;
          end else begin
            credit_d = coin_sum[7:0];
            state_d  = StCollect;
          end
        end
      end
      StDispense: begin
        deny_d = |bus.flag_key;
        if (timer_q == DispLast) begin
          timer_d = '0;
          state_d = (credit_q != 8'd0) ? StCollect : StIdle;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StRefund: begin
        deny_d  = |bus.flag_key;
        timer_d = (timer_q == RetLast) ? 32'd0 : timer_q + 32'd1;
        if (ret_pulse) begin
          credit_d = credit_q - COIN_C05;
          if (credit_q == COIN_C05) begin
            state_d = StIdle;
            timer_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  vend_bin2bcd u_credit_bcd (
    .bin_i (credit_q),
    .bcd_o (credit_bcd)
  );

  vend_bin2bcd u_sold_bcd (
    .bin_i ({1'b0, sold_q}),
    .bcd_o (sold_bcd)
  );

  assign rnum_d = {sold_bcd[7:0], credit_bcd, 4'h0};

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q  <= StIdle;
      credit_q <= '0;
      sold_q   <= '0;
      timer_q  <= '0;
      deny_q   <= 1'b0;
      rnum_q   <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sold_q   <= sold_d;
      timer_q  <= timer_d;
      deny_q   <= deny_d;
      rnum_q   <= rnum_d;
    end
  end

  assign bus.rNum     = rnum_q;
  assign bus.dispense = (state_q == StDispense);
  assign bus.busy     = (state_q == StDispense) || (state_q == StRefund);
  assign bus.coin_ret = ret_pulse;
  assign bus.deny     = deny_q;

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Self-checking bench for vend_seq_ctrl with short dispense/return timing.
module tb_vend_seq_ctrl;

  localparam logic [3:0] K0  = 4'b0000;
  localparam logic [3:0] C05 = 4'b0001;
  localparam logic [3:0] C10 = 4'b0010;
  localparam logic [3:0] CAN = 4'b0100;
  localparam logic [3:0] BUY = 4'b1000;

  typedef struct packed {
    logic        rst;
    logic [3:0]  key;
    logic [23:0] rnum;
    logic        disp;
    logic        cret;
    logic        deny;
    logic        busy;
  } vec_t;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  vend_seq_ctrl_if bus ();

  vend_seq_ctrl #(
    .PRICE      (25),
    .CREDIT_MAX (200),
    .DISP_CYC   (4),
    .RET_GAP    (3)
  ) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

  // Expected display word from sold count and credit in jiao.
  function automatic logic [23:0] w(input int sold, input int credit);
    return {4'((sold / 10) % 10), 4'(sold % 10), 4'(credit / 100), 4'((credit / 10) % 10),
            4'(credit % 10), 4'h0};
  endfunction

  task automatic add(input logic r, input logic [3:0] k, input logic [23:0] rn,
                     input logic d, input logic c, input logic dn, input logic b);
    vec_t v;
    v.rst = r; v.key = k; v.rnum = rn; v.disp = d; v.cret = c; v.deny = dn; v.busy = b;
    tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check after the edge.
  task automatic step(input vec_t v, input int id);
    vec_t e;
    rst = v.rst;
    bus.flag_key = v.key;
    exp_q.push_back(v);
    @(posedge sclk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL vec_%0d: scoreboard empty", id);
    end else begin
      e = exp_q.pop_front();
      if (bus.rNum !== e.rnum || bus.dispense !== e.disp || bus.coin_ret !== e.cret ||
          bus.deny !== e.deny || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL vec_%0d: got rNum=%h disp=%b ret=%b deny=%b busy=%b, want rNum=%h disp=%b ret=%b deny=%b busy=%b",
                 id, bus.rNum, bus.dispense, bus.coin_ret, bus.deny, bus.busy,
                 e.rnum, e.disp, e.cret, e.deny, e.busy);
      end
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] k);
    rst = r;
    bus.flag_key = k;
    @(posedge sclk);
    #1;
  endtask

  initial begin
    vec_t v;
    bus.flag_key = K0;

    // Reset and idle
    add(1, K0, 24'h0, 0, 0, 0, 0);
    add(0, K0, 24'h0, 0, 0, 0, 0);
    // 1 + 1 + 0.5 yuan then buy at exactly the price
    add(0, C10, w(0, 0), 0, 0, 0, 0);
    add(0, C10, w(0, 10), 0, 0, 0, 0);
    add(0, C05, w(0, 20), 0, 0, 0, 0);
    add(0, K0,  w(0, 25), 0, 0, 0, 0);
    add(0, BUY, w(0, 25), 1, 0, 0, 1);
    add(0, K0,  w(1, 0), 1, 0, 0, 1);
    add(0, K0,  w(1, 0), 1, 0, 0, 1);
    add(0, K0,  w(1, 0), 1, 0, 0, 1);
    add(0, K0,  w(1, 0), 0, 0, 0, 0);
    // Buy with too little credit
    add(0, C10, w(1, 0), 0, 0, 0, 0);
    add(0, BUY, w(1, 10), 0, 0, 1, 0);
    add(0, K0,  w(1, 10), 0, 0, 0, 0);
    // Cancel with 15 jiao: three paced returns
    add(0, C05, w(1, 10), 0, 0, 0, 0);
    add(0, K0,  w(1, 15), 0, 0, 0, 0);
    add(0, CAN, w(1, 15), 0, 1, 0, 1);
    add(0, K0,  w(1, 15), 0, 0, 0, 1);
    add(0, K0,  w(1, 10), 0, 0, 0, 1);
    add(0, K0,  w(1, 10), 0, 1, 0, 1);
    add(0, K0,  w(1, 10), 0, 0, 0, 1);
    add(0, K0,  w(1, 5), 0, 0, 0, 1);
    add(0, K0,  w(1, 5), 0, 1, 0, 1);
    add(0, K0,  w(1, 5), 0, 0, 0, 0);
    add(0, K0,  w(1, 0), 0, 0, 0, 0);
    add(0, CAN, w(1, 0), 0, 0, 0, 0);
    // All keys at once with 10 jiao: only cancel acts
    add(0, C10,   w(1, 0), 0, 0, 0, 0);
    add(0, K0,    w(1, 10), 0, 0, 0, 0);
    add(0, 4'hF,  w(1, 10), 0, 1, 0, 1);
    add(0, K0,    w(1, 10), 0, 0, 0, 1);
    add(0, K0,    w(1, 5), 0, 0, 0, 1);
    // Reset in the second gap cycle aborts the refund
    add(1, K0, 24'h0, 0, 0, 0, 0);
    add(0, K0, 24'h0, 0, 0, 0, 0);
    add(0, K0, 24'h0, 0, 0, 0, 0);
    add(0, K0, 24'h0, 0, 0, 0, 0);
    // Fill to the ceiling, then overflow and keys during dispense
    for (int i = 1; i <= 20; i++) add(0, C10, w(0, 10 * (i - 1)), 0, 0, 0, 0);
    add(0, C05, w(0, 200), 0, 0, 1, 0);
    add(0, C10, w(0, 200), 0, 0, 1, 0);
    add(0, K0,  w(0, 200), 0, 0, 0, 0);
    add(0, BUY, w(0, 200), 1, 0, 0, 1);
    add(0, C05, w(1, 175), 1, 0, 1, 1);
    add(0, K0,  w(1, 175), 1, 0, 0, 1);
    add(0, K0,  w(1, 175), 1, 0, 0, 1);
    add(0, K0,  w(1, 175), 0, 0, 0, 0);
    add(0, BUY, w(1, 175), 1, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // 100 sales: sold field must count through 99 and wrap to 00
    drive(1, K0);
    for (int s = 1; s <= 100; s++) begin
      drive(0, C10);
      drive(0, C10);
      drive(0, C05);
      drive(0, BUY);
      drive(0, K0);
      drive(0, K0);
      drive(0, K0);
      v.rst = 1'b0; v.key = K0; v.rnum = w(s % 100, 0);
      v.disp = 1'b0; v.cret = 1'b0; v.deny = 1'b0; v.busy = 1'b0;
      step(v, 1000 + s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
